// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: ALU opcodes, major opcodes, funct7
// values and the decoded bundle that is registered toward the ALU.
package rv32i_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_XOR  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } aluop_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    aluop_e      aluop;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        illegal;
  } decoded_t;

  // alt selects SUB/SRA; the caller only sets it where funct7 is meaningful.
  function automatic aluop_e alu_from_funct3(input logic [2:0] f3, input logic alt);
    aluop_e r;
    r = ALU_ADD;
    case (f3)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv32i_alu_decode_if.sv
// Fetch -> decode -> execute bus. Handshake: a transfer happens on a rising
// edge where valid and ready are both high; valid must not depend on ready.
// illegal_instr exists only when RV32I_ILLEGAL_DETECT_EN is defined.
interface rv32i_alu_decode_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic [3:0]  aluop;
  logic [4:0]  rd_addr;
  logic        rd_we;
`ifdef RV32I_ILLEGAL_DETECT_EN
  logic        illegal_instr;

  modport master (
    output in_valid, in_instr, in_pc, rs1_data, rs2_data, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, operand_1, operand_2,
           aluop, rd_addr, rd_we, illegal_instr
  );
  modport slave (
    input  in_valid, in_instr, in_pc, rs1_data, rs2_data, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, operand_1, operand_2,
           aluop, rd_addr, rd_we, illegal_instr
  );
`else
  modport master (
    output in_valid, in_instr, in_pc, rs1_data, rs2_data, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, operand_1, operand_2,
           aluop, rd_addr, rd_we
  );
  modport slave (
    input  in_valid, in_instr, in_pc, rs1_data, rs2_data, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, operand_1, operand_2,
           aluop, rd_addr, rd_we
  );
`endif
endinterface

// File: rtl/rv32i_imm_gen.sv
// Immediate extraction for the ALU decode: I-type (sign-extended),
// U-type (upper 20 bits) and zero-extended shift amount.
module rv32i_imm_gen (
  input  logic [31:12] instr_i,
  output logic [31:0]  i_imm_o,
  output logic [31:0]  u_imm_o,
  output logic [31:0]  shamt_o
);

  assign i_imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
  assign u_imm_o = {instr_i[31:12], 12'b0};
  assign shamt_o = {27'b0, instr_i[24:20]};

endmodule

// File: rtl/rv32i_alu_decode.sv
// RV32I decode stage feeding the ALU: decodes OP, OP-IMM, LUI and AUIPC
// into operands and an ALU opcode, held in one registered output slot.
// Optional feature macro: RV32I_ILLEGAL_DETECT_EN (deliver illegal
// instructions flagged instead of dropping them).
module rv32i_alu_decode
  import rv32i_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  rv32i_alu_decode_if.slave bus
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] u_imm;
  logic [XLEN-1:0] shamt;
  logic            legal;
  logic            keep;
  logic            in_ready;
  logic            accept;
  decoded_t        dec;
  decoded_t        bundle_d, bundle_q;
  logic            valid_d, valid_q;

  assign opcode = bus.in_instr[6:0];
  assign rd     = bus.in_instr[11:7];
  assign funct3 = bus.in_instr[14:12];
  assign funct7 = bus.in_instr[31:25];

  assign bus.rs1_addr = bus.in_instr[19:15];
  assign bus.rs2_addr = bus.in_instr[24:20];

  rv32i_imm_gen u_imm_gen (
    .instr_i (bus.in_instr[31:12]),
    .i_imm_o (i_imm),
    .u_imm_o (u_imm),
    .shamt_o (shamt)
  );

  // Decode the incoming instruction into an ALU bundle.
  always_comb begin
    dec   = '0;
    legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        legal           = (funct7 == F7_ZERO) ||
                          ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec.operand_1   = bus.rs1_data;
        dec.operand_2   = bus.rs2_data;
        dec.aluop       = alu_from_funct3(funct3, funct7 == F7_ALT);
      end
      OPC_OP_IMM: begin
        dec.operand_1 = bus.rs1_data;
        case (funct3)
          3'b001: begin
            dec.operand_2 = shamt;
            legal         = (funct7 == F7_ZERO);
          end
          3'b101: begin
            dec.operand_2 = shamt;
            legal         = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
          end
          default: begin
            dec.operand_2 = i_imm;
            legal         = 1'b1;
          end
        endcase
        // Upper immediate bits only carry meaning for the right shifts.
        dec.aluop = alu_from_funct3(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
      end
      OPC_LUI: begin
        legal         = 1'b1;
        dec.operand_1 = '0;
        dec.operand_2 = u_imm;
        dec.aluop     = ALU_ADD;
      end
      OPC_AUIPC: begin
        legal         = 1'b1;
        dec.operand_1 = bus.in_pc;
        dec.operand_2 = u_imm;
        dec.aluop     = ALU_ADD;
      end
      default: legal = 1'b0;
    endcase
    dec.rd_addr = rd;
    dec.rd_we   = legal && (rd != 5'd0);
    dec.illegal = !legal;
    if (!legal) begin
      dec.operand_1 = '0;
      dec.operand_2 = '0;
      dec.aluop     = ALU_ADD;
    end
  end

`ifdef RV32I_ILLEGAL_DETECT_EN
  assign keep = 1'b1;
  assign bus.illegal_instr = bundle_q.illegal;
`else
  // Illegal instructions are consumed but never occupy the slot.
  assign keep = legal;
  logic unused_illegal;
  assign unused_illegal = bundle_q.illegal;
`endif

  assign in_ready     = !flush && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && in_ready;
  assign bus.in_ready = in_ready;

  // Output slot next state: flush kills, accept refills, drain empties.
  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = keep;
      if (keep) bundle_d = dec;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output slot register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.operand_1 = bundle_q.operand_1;
  assign bus.operand_2 = bundle_q.operand_2;
  assign bus.aluop     = bundle_q.aluop;
  assign bus.rd_addr   = bundle_q.rd_addr;
  assign bus.rd_we     = bundle_q.rd_we;

endmodule

// File: tb/tb_rv32i_alu_decode.sv
// Bench for rv32i_alu_decode: directed decode cases, backpressure, flush,
// reset, throughput, illegal handling and randomized OP/OP-IMM traffic.
module tb_rv32i_alu_decode;

  localparam int W = 75;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  bit   rand_ready = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] exp_q[$];
  logic [3:0] alu_tab [8] = '{4'h0, 4'h5, 4'h8, 4'h9, 4'h2, 4'h6, 4'h3, 4'h4};

  always #5 clk = ~clk;

  rv32i_alu_decode_if bus();

  rv32i_alu_decode #(.XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  function automatic logic [W-1:0] mk(input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] op, input logic [4:0] rd,
                                      input logic we, input logic ill);
    return {a, b, op, rd, we, ill};
  endfunction

  function automatic logic [W-1:0] observed();
    logic ill;
`ifdef RV32I_ILLEGAL_DETECT_EN
    ill = bus.illegal_instr;
`else
    ill = 1'b0;
`endif
    return {bus.operand_1, bus.operand_2, bus.aluop, bus.rd_addr, bus.rd_we, ill};
  endfunction

  // Scoreboard: every bundle consumed by the execute side is compared.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got=%h", observed());
      end else begin
        e = exp_q.pop_front();
        if (observed() !== e) begin
          errors++;
          $display("FAIL bundle got=%h exp=%h", observed(), e);
        end
      end
    end
  end

  // Random consumer backpressure during the random test.
  always @(posedge clk) begin
    #1;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one instruction and hold it until accepted (bounded).
  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic [W-1:0] e, input bit push);
    bit acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    bus.rs1_data = r1;
    bus.rs2_data = r2;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1'b1;
        if (push) exp_q.push_back(e);
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (bus.rs1_addr !== instr[19:15] || bus.rs2_addr !== instr[24:20]) begin
      errors++;
      $display("FAIL rs_addr got=%h/%h exp=%h/%h", bus.rs1_addr, bus.rs2_addr,
               instr[19:15], instr[24:20]);
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout instr=%h got=0 exp=1", instr);
    end else begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_instr = '0; bus.in_pc = '0; bus.rs1_data = '0; bus.rs2_data = '0;
    idle(3);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (observed() !== '0) begin errors++; $display("FAIL rst_bundle got=%h exp=0", observed()); end
    rst = 1'b0;
    idle(1);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%b exp=1", bus.in_ready); end
    // Reset while a bundle is stalled in the slot.
    send(32'h00500093, 32'h0, 32'h0, 32'h0, '0, 1'b0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid got=%b exp=1", bus.out_valid); end
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", bus.out_valid); end
    checks++; if (observed() !== '0) begin errors++; $display("FAIL midrst_bundle got=%h exp=0", observed()); end
  endtask

  task automatic test_decode();
    bus.out_ready = 1'b1;
    send(32'h00500093, 32'h0, 32'h0, 32'h0, mk(32'h0, 32'h5, 4'h0, 5'd1, 1'b1, 1'b0), 1'b1);
    send(32'hFFF00093, 32'h0, 32'h7, 32'h0, mk(32'h7, 32'hFFFFFFFF, 4'h0, 5'd1, 1'b1, 1'b0), 1'b1);
    send(32'h00000013, 32'h0, 32'h0, 32'h0, mk(32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0), 1'b1);
    send(32'h402081B3, 32'h0, 32'd10, 32'd3, mk(32'd10, 32'd3, 4'h1, 5'd3, 1'b1, 1'b0), 1'b1);
    send(32'h0020D233, 32'h0, 32'h80, 32'h2, mk(32'h80, 32'h2, 4'h6, 5'd4, 1'b1, 1'b0), 1'b1);
    send(32'h40335293, 32'h0, 32'hF0000000, 32'h0, mk(32'hF0000000, 32'h3, 4'h7, 5'd5, 1'b1, 1'b0), 1'b1);
    send(32'h123453B7, 32'h0, 32'h55, 32'h0, mk(32'h0, 32'h12345000, 4'h0, 5'd7, 1'b1, 1'b0), 1'b1);
    send(32'h12345397, 32'h100, 32'h0, 32'h0, mk(32'h100, 32'h12345000, 4'h0, 5'd7, 1'b1, 1'b0), 1'b1);
    idle(2);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    held = mk(32'd10, 32'd3, 4'h1, 5'd3, 1'b1, 1'b0);
    bus.out_ready = 1'b0;
    send(32'h402081B3, 32'h0, 32'd10, 32'd3, held, 1'b1);
    bus.in_valid = 1'b1; bus.in_instr = 32'h00500093; bus.rs1_data = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1 || observed() !== held) begin
        errors++; $display("FAIL bp_hold c=%0d got=%b/%h exp=1/%h", c, bus.out_valid, observed(), held);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    // Drain and refill on the same edge.
    bus.out_ready = 1'b1;
    send(32'h00500093, 32'h0, 32'h0, 32'h0, mk(32'h0, 32'h5, 4'h0, 5'd1, 1'b1, 1'b0), 1'b1);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL refill_valid got=%b exp=1", bus.out_valid); end
    idle(2);
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    send(32'h00500093, 32'h0, 32'h0, 32'h0, '0, 1'b0);
    flush = 1'b1;
    bus.in_valid = 1'b1; bus.in_instr = 32'h402081B3;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b exp=0", bus.in_ready); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid); end
    // Flush wins over an accept into an empty slot.
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_prec_ready got=%b exp=0", bus.in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_prec_valid got=%b exp=0", bus.out_valid); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    time t0;
    bus.out_ready = 1'b1;
    t0 = $time;
    for (int i = 0; i < 8; i++) begin
      send({12'(i * 3), 5'd2, 3'b000, 5'(i + 8), 7'h13}, 32'h0, 32'(i), 32'h0,
           mk(32'(i), 32'(i * 3), 4'h0, 5'(i + 8), 1'b1, 1'b0), 1'b1);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid i=%0d got=%b exp=1", i, bus.out_valid); end
    end
    checks++;
    if (($time - t0) != 80) begin
      errors++; $display("FAIL b2b_throughput got=%0t exp=80", $time - t0);
    end
    idle(2);
  endtask

  task automatic test_illegal();
    logic [31:0] ill_instr [4] = '{32'h0000000F, 32'h022081B3, 32'h40109093, 32'h402091B3};
    logic [4:0]  ill_rd    [4] = '{5'd0, 5'd3, 5'd1, 5'd3};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef RV32I_ILLEGAL_DETECT_EN
      send(ill_instr[i], 32'h40, 32'h1234, 32'h5678, mk(32'h0, 32'h0, 4'h0, ill_rd[i], 1'b0, 1'b1), 1'b1);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL illegal_valid i=%0d got=%b exp=1", i, bus.out_valid); end
`else
      send(ill_instr[i], 32'h40, 32'h1234, 32'h5678, mk(32'h0, 32'h0, 4'h0, ill_rd[i], 1'b0, 1'b1), 1'b0);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL illegal_valid i=%0d got=%b exp=0", i, bus.out_valid); end
`endif
    end
    idle(2);
    // Illegal instruction arriving as a stalled legal one drains.
    bus.out_ready = 1'b0;
    send(32'h00500093, 32'h0, 32'h0, 32'h0, mk(32'h0, 32'h5, 4'h0, 5'd1, 1'b1, 1'b0), 1'b1);
    bus.out_ready = 1'b1;
`ifdef RV32I_ILLEGAL_DETECT_EN
    send(32'h0000000F, 32'h0, 32'h0, 32'h0, mk(32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b1), 1'b1);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL illegal_drain got=%b exp=1", bus.out_valid); end
`else
    send(32'h0000000F, 32'h0, 32'h0, 32'h0, '0, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL illegal_drain got=%b exp=0", bus.out_valid); end
`endif
    idle(2);
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [4:0]  rd, ra, rb;
    logic [11:0] imm;
    logic [31:0] r1, r2, instr, b;
    logic [3:0]  op;
    bit          alt;
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 31));
      ra = 5'($urandom_range(0, 31));
      rb = 5'($urandom_range(0, 31));
      r1 = $urandom;
      r2 = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        alt   = (f3 == 3'd0 || f3 == 3'd5) && ($urandom_range(0, 1) == 1);
        instr = {(alt ? 7'h20 : 7'h00), rb, ra, f3, rd, 7'h33};
        op    = alt ? ((f3 == 3'd0) ? 4'h1 : 4'h7) : alu_tab[f3];
        b     = r2;
      end else begin
        imm = 12'($urandom_range(0, 4095));
        if (f3 == 3'd1) imm[11:5] = 7'h00;
        if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        instr = {imm, ra, f3, rd, 7'h13};
        b     = (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, imm[4:0]} : {{20{imm[11]}}, imm};
        op    = (f3 == 3'd5 && imm[10]) ? 4'h7 : alu_tab[f3];
      end
      send(instr, 32'h0, r1, r2, mk(r1, b, op, rd, rd != 5'd0, 1'b0), 1'b1);
    end
    rand_ready = 1'b0;
    idle(1);
    bus.out_ready = 1'b1;
    idle(3);
  endtask

  initial begin
    test_reset();
    test_decode();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_illegal();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_alu_decode.md
# rv32i_alu_decode

Decode stage that drives the RV32I ALU. It accepts a fetched instruction and its PC over a valid/ready handshake and reads the register file combinationally. It decodes OP, OP-IMM, LUI and AUIPC into `operand_1`, `operand_2` and a 4-bit `aluop`. Results are presented through a single registered output slot with backpressure, placed between fetch and the execute/ALU stage.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock; the block has one clock.
- rst  in  1  reset, synchronous and active-high.
- flush  in  1  kill in-flight decode, synchronous.
- in_valid  in  1  instruction/PC valid.
- in_ready  out  1  slot can accept this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  32  instruction address.
- rs1_addr  out  5  combinational `in_instr[19:15]`.
- rs2_addr  out  5  combinational `in_instr[24:20]`.
- rs1_data  in  32  register file read data for rs1, same cycle.
- rs2_data  in  32  register file read data for rs2, same cycle.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute stage accepts.
- operand_1  out  32  ALU operand 1.
- operand_2  out  32  ALU operand 2.
- aluop  out  4  ALU opcode.
- rd_addr  out  5  destination register.
- rd_we  out  1  writeback enable; forced to 0 when rd_addr is 0.
- illegal_instr  out  1  present only with the macro (see Configuration).

## Operation
- aluop encoding: ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
- funct3 mapping:
  - 000 → ADD, or SUB when the opcode is OP and funct7 is 0100000.
  - 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR.
  - 101 → SRL when funct7 is 0000000, SRA when funct7 is 0100000.
  - 110 → OR; 111 → AND.
- OP (0110011):
  - operand_1 = rs1_data, operand_2 = rs2_data.
  - funct7 outside {0000000, 0100000} is illegal.
  - funct7 = 0100000 is legal only with funct3 000 or 101.
- OP-IMM (0010011):
  - operand_1 = rs1_data, operand_2 = sign-extended `instr[31:20]`.
  - For shifts, operand_2 = {27'b0, instr[24:20]}.
  - SLLI requires funct7 = 0; SRLI/SRAI require funct7 to be 0000000 or 0100000. Anything else is illegal.
- LUI (0110111): operand_1 = 0, operand_2 = {instr[31:12], 12'b0}, aluop = ADD.
- AUIPC (0010111): operand_1 = in_pc, operand_2 = {instr[31:12], 12'b0}, aluop = ADD.
- Any other opcode is illegal.
- Illegal instructions always have rd_we = 0.
- rd_addr = `instr[11:7]`.

## Timing
- Reset values: out_valid 0, operand_1 0, operand_2 0, aluop 0000, rd_addr 0, rd_we 0, illegal_instr 0.
- in_ready = !flush && (!out_valid || out_ready). The block is combinational from out_ready.
- Accept condition: in_valid && in_ready. The decoded bundle is registered and out_valid rises on the next edge (latency 1).
- Throughput: 1 instruction per cycle while out_ready is held high.
- Backpressure: while out_valid && !out_ready, all outputs hold stable.
- Simultaneous consume and accept: when the slot is drained and refilled in the same cycle, out_valid stays 1 and the bundle is replaced.
- flush high: out_valid is 0 on the next edge and no input is accepted that cycle. flush takes precedence over accept.
- rst high mid-transfer: the same effect as flush, plus all outputs return to their reset values.

## Configuration
- RV32I_ILLEGAL_DETECT_EN defined:
  - The `illegal_instr` port exists.
  - An illegal instruction is delivered with out_valid = 1, illegal_instr = 1, rd_we = 0, and operands/aluop zero.
- Macro undefined:
  - No `illegal_instr` port.
  - An illegal instruction is consumed (in_ready behaves normally) but never raises out_valid. The slot empties if it was being drained.

## Structure
- Shared package `rv32i_pkg`:
  - aluop constants ADD through SLTU.
  - Opcode constants OP, OP_IMM, LUI, AUIPC.
  - funct7 constants 0000000 and 0100000.
  - The decoded-bundle struct.
- One combinational sub-module, `rv32i_imm_gen`, produces the I-immediate, U-immediate and shamt.
- The top level holds the decode case and the output register.

## Test plan
- ADDI x1,x0,5: in_instr 0x00500093, rs1_data 0 → next cycle aluop 0000, operand_1 0, operand_2 5, rd_addr 1, rd_we 1.
- SUB x3,x1,x2: in_instr 0x402081B3, rs1_data 10, rs2_data 3 → aluop 0001, operand_1 10, operand_2 3, rd_addr 3.
- SRAI x5,x6,3: in_instr 0x40335293, rs1_data 0xF0000000 → aluop 0111, operand_2 3.
- LUI and AUIPC:
  - LUI x7,0x12345: in_instr 0x123453B7 → operand_1 0, operand_2 0x12345000, aluop 0000.
  - AUIPC with in_pc 0x100 → operand_1 0x100.
- Backpressure and flush:
  - With out_ready held 0 for 3 cycles, outputs are stable and in_ready is 0.
  - Raising flush clears out_valid the next cycle.
  - Back-to-back accepts with out_ready 1 give 1 instruction per cycle.
- Illegal input in_instr 0x0000000F (FENCE):
  - Macro defined: out_valid 1, illegal_instr 1, rd_we 0.
  - Macro undefined: no out_valid pulse.
